// File: rtl/cnn_stream_pkg.sv
// Shared constants and helpers for the padded CNN pixel-stream blocks.
//   KERNEL_SIZE : side of the square convolution window
//   pad_dim()   : padded frame dimension from image dimension and padding
//   win_idx()   : flat tap index of window element (row, col)
package cnn_stream_pkg;

    localparam int unsigned KERNEL_SIZE = 3;
    localparam int unsigned WIN_TAPS    = KERNEL_SIZE * KERNEL_SIZE;

    // Padded dimension: image plus padding on both sides.
    function automatic int unsigned pad_dim(input int unsigned img, input int unsigned pad);
        return img + 2 * pad;
    endfunction

    // Row-major tap index inside the window; r=0 is the oldest row, c=0 the leftmost column.
    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return r * KERNEL_SIZE + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One padded-row line buffer: registered write, combinational read of the old value.
//   clk       : clock
//   wr_en     : write the addressed entry with wr_data
//   addr      : column address (read and write share it)
//   wr_data   : value to store
//   rd_data_c : current (pre-write) contents of the addressed entry
module conv_line_buffer #(
    parameter int unsigned DEPTH = 6,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data_c
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data_c = mem[addr];

endmodule

// File: rtl/conv_window_3x3_axis.sv
// 3x3 sliding-window generator over a zero-padded AXI-Stream pixel frame.
// Emits one full neighbourhood per output position (all 9 taps in one beat).
//   clk, reset        : clock, synchronous active-high reset
//   s00_axis_*        : padded pixel stream in (tuser = frame start, tlast = row end)
//   m00_axis_*        : window stream out (tuser = first window, tlast = row end)
//   frame_err         : sticky framing error, cleared only by reset
module conv_window_3x3_axis
    import cnn_stream_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned IMG_WIDTH          = 640,
    parameter int unsigned IMG_HEIGHT         = 480,
    parameter int unsigned NUM_PADDING        = 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         s00_axis_tvalid,
    output logic                                         s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]                s00_axis_tdata,
    input  logic                                         s00_axis_tlast,
    input  logic                                         s00_axis_tuser,
    output logic                                         m00_axis_tvalid,
    input  logic                                         m00_axis_tready,
    output logic [WIN_TAPS*C_AXIS_TDATA_WIDTH-1:0]       m00_axis_tdata,
    output logic                                         m00_axis_tlast,
    output logic                                         m00_axis_tuser,
    output logic                                         frame_err
);

    localparam int unsigned DW    = C_AXIS_TDATA_WIDTH;
    localparam int unsigned K     = KERNEL_SIZE;
    localparam int unsigned OW    = WIN_TAPS * DW;
    localparam int unsigned PAD_W = pad_dim(IMG_WIDTH, NUM_PADDING);
    localparam int unsigned PAD_H = pad_dim(IMG_HEIGHT, NUM_PADDING);
    localparam int unsigned CW    = $clog2(PAD_W);
    localparam int unsigned RW    = $clog2(PAD_H);

    logic [CW-1:0] col, col_nxt, eff_col;
    logic [RW-1:0] row, row_nxt, eff_row;
    logic [DW-1:0] win     [K][K];
    logic [DW-1:0] win_nxt [K][K];
    logic [DW-1:0] lb0_rd_c, lb1_rd_c;
    logic          accept_c, at_row_end_c;
    logic          tvalid_nxt, tlast_nxt, tuser_nxt, err_nxt;
    logic [OW-1:0] tdata_nxt;

    assign s00_axis_tready = !m00_axis_tvalid || m00_axis_tready;
    assign accept_c        = s00_axis_tvalid && s00_axis_tready;

    // lb0 holds row-1; its old value cascades into lb1 (row-2) on the same write.
    conv_line_buffer #(.DEPTH(PAD_W), .WIDTH(DW)) u_lb0 (
        .clk       (clk),
        .wr_en     (accept_c),
        .addr      (eff_col),
        .wr_data   (s00_axis_tdata),
        .rd_data_c (lb0_rd_c)
    );

    conv_line_buffer #(.DEPTH(PAD_W), .WIDTH(DW)) u_lb1 (
        .clk       (clk),
        .wr_en     (accept_c),
        .addr      (eff_col),
        .wr_data   (lb0_rd_c),
        .rd_data_c (lb1_rd_c)
    );

    // Next-state: position tracking, framing checks, window shift and output load.
    always_comb begin
        eff_col      = col;
        eff_row      = row;
        col_nxt      = col;
        row_nxt      = row;
        err_nxt      = frame_err;
        win_nxt      = win;
        tvalid_nxt   = m00_axis_tvalid && !m00_axis_tready;
        tdata_nxt    = m00_axis_tdata;
        tlast_nxt    = m00_axis_tlast;
        tuser_nxt    = m00_axis_tuser;

        // A frame-start marker always wins: the pixel is treated as (0,0).
        if (s00_axis_tuser) begin
            eff_col = '0;
            eff_row = '0;
        end
        at_row_end_c = (eff_col == CW'(PAD_W - 1));

        if (accept_c) begin
            if (s00_axis_tuser && ((row != '0) || (col != '0))) begin
                err_nxt = 1'b1;
            end
            if (s00_axis_tlast != at_row_end_c) begin
                err_nxt = 1'b1;
            end

            // An early tlast also closes the row so the stream resyncs.
            if (s00_axis_tlast || at_row_end_c) begin
                col_nxt = '0;
                row_nxt = (eff_row == RW'(PAD_H - 1)) ? '0 : eff_row + RW'(1);
            end else begin
                col_nxt = eff_col + CW'(1);
                row_nxt = eff_row;
            end

            for (int unsigned r = 0; r < K; r++) begin
                for (int unsigned c = 0; c < K - 1; c++) begin
                    win_nxt[r][c] = win[r][c+1];
                end
            end
            win_nxt[0][K-1] = lb1_rd_c;
            win_nxt[1][K-1] = lb0_rd_c;
            win_nxt[2][K-1] = s00_axis_tdata;

            if ((eff_col >= CW'(K - 1)) && (eff_row >= RW'(K - 1))) begin
                tvalid_nxt = 1'b1;
                tuser_nxt  = (eff_col == CW'(K - 1)) && (eff_row == RW'(K - 1));
                tlast_nxt  = at_row_end_c;
                for (int unsigned r = 0; r < K; r++) begin
                    for (int unsigned c = 0; c < K; c++) begin
                        tdata_nxt[win_idx(r, c)*DW +: DW] = win_nxt[r][c];
                    end
                end
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            col             <= '0;
            row             <= '0;
            frame_err       <= 1'b0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tuser  <= 1'b0;
        end else begin
            col             <= col_nxt;
            row             <= row_nxt;
            frame_err       <= err_nxt;
            m00_axis_tvalid <= tvalid_nxt;
            m00_axis_tdata  <= tdata_nxt;
            m00_axis_tlast  <= tlast_nxt;
            m00_axis_tuser  <= tuser_nxt;
        end
    end

    // Window taps never feed an output before being refilled, so they carry no reset.
    always_ff @(posedge clk) begin
        win <= win_nxt;
    end

endmodule
